branch_predictor_btb: RTL and testbench

//  Direct-mapped branch target buffer with 2-bit saturating counters; supplies the fetch stage with a

---
 rtl/branch_predictor_btb.sv | 111 +++++++++++
 tb/tb_branch_predictor_btb.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit saturating counters and EX-stage mispredict/redirect generation.
// Optional statistics counters are enabled by defining BTB_STATS_EN.
module branch_predictor_btb #(
  parameter int ENTRIES    = 64,
  parameter int INDEX_BITS = 6
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        BrInstE,
  input  logic        BranchE,
  input  logic [31:0] PCE,
  input  logic [31:0] BrTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] RedirectPCE,
  output logic [31:0] BrCount,
  output logic [31:0] MissCount
);

  localparam int TAG_BITS = 30 - INDEX_BITS;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] idx_f, idx_e;
  logic [TAG_BITS-1:0]   tag_f, tag_e;
  logic                  hit_f, hit_e;
  logic                  unused_pc_bits;

  assign idx_f = PCF[INDEX_BITS+1:2];
  assign tag_f = PCF[31:INDEX_BITS+2];
  assign idx_e = PCE[INDEX_BITS+1:2];
  assign tag_e = PCE[31:INDEX_BITS+2];
  assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  // Fetch lookup reads the stored state only, so a same-cycle update is seen one cycle later.
  always_comb begin
    hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    PredTakenF  = hit_f && ctr_q[idx_f][1];
    PredTargetF = PredTakenF ? target_q[idx_f] : PCF + 32'd4;
  end

  always_comb begin
    hit_e       = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    MispredictE = BrInstE && ((PredTakenE != BranchE) ||
                              (BranchE && (PredTargetE != BrTargetE)));
    RedirectPCE = BranchE ? BrTargetE : PCE + 32'd4;
  end

  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      valid_q <= '0;
    end else if (BrInstE && BranchE && !hit_e) begin
      valid_q[idx_e] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; gating on CPU_RST keeps a coincident update from landing.
  always_ff @(posedge CPU_CLK) begin
    if (BrInstE && !CPU_RST) begin
      if (hit_e) begin
        if (BranchE) begin
          ctr_q[idx_e]    <= sat_inc(ctr_q[idx_e]);
          target_q[idx_e] <= BrTargetE;
        end else begin
          ctr_q[idx_e]    <= sat_dec(ctr_q[idx_e]);
        end
      end else if (BranchE) begin
        tag_q[idx_e]    <= tag_e;
        target_q[idx_e] <= BrTargetE;
        ctr_q[idx_e]    <= 2'b10;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] br_count_q;
  logic [31:0] miss_count_q;

  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else begin
      if (BrInstE)     br_count_q   <= br_count_q + 32'd1;
      if (MispredictE) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign BrCount   = br_count_q;
  assign MissCount = miss_count_q;
`else
  assign BrCount   = '0;
  assign MissCount = '0;
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb against a behavioural BTB model.
module tb_branch_predictor_btb;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST = 1'b0;
  logic [31:0] PCF = '0;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        BrInstE = 1'b0;
  logic        BranchE = 1'b0;
  logic [31:0] PCE = '0;
  logic [31:0] BrTargetE = '0;
  logic        PredTakenE = 1'b0;
  logic [31:0] PredTargetE = '0;
  logic        MispredictE;
  logic [31:0] RedirectPCE;
  logic [31:0] BrCount;
  logic [31:0] MissCount;

  int errors = 0;
  int checks = 0;

  branch_predictor_btb #(.ENTRIES(64), .INDEX_BITS(6)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST), .PCF(PCF),
    .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .BrInstE(BrInstE), .BranchE(BranchE), .PCE(PCE), .BrTargetE(BrTargetE),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .MispredictE(MispredictE), .RedirectPCE(RedirectPCE),
    .BrCount(BrCount), .MissCount(MissCount)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Behavioural model: each slot remembers which PC owns it, its target and a 0..3 confidence.
  bit          m_valid [64];
  bit [31:0]   m_owner [64];
  bit [31:0]   m_tgt   [64];
  int          m_conf  [64];
  logic [31:0] exp_br, exp_miss;

  function automatic int slot(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_owner[slot(pc)][31:8] == pc[31:8]);
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_conf[slot(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc);
    return m_taken(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_mispredict(input bit tk, input logic [31:0] tgt,
                                      input bit pt, input logic [31:0] ptgt);
    return (pt != tk) || (tk && (ptgt != tgt));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    exp_br = '0;
    exp_miss = '0;
  endtask

  // Applies the effect of the upcoming clock edge for the currently driven EX inputs.
  task automatic model_update();
    int s;
    if (!BrInstE) return;
    s = slot(PCE);
    exp_br = exp_br + 32'd1;
    if (m_mispredict(BranchE, BrTargetE, PredTakenE, PredTargetE)) exp_miss = exp_miss + 32'd1;
    if (m_hit(PCE)) begin
      if (BranchE) begin
        m_conf[s] = (m_conf[s] == 3) ? 3 : m_conf[s] + 1;
        m_tgt[s]  = BrTargetE;
      end else begin
        m_conf[s] = (m_conf[s] == 0) ? 0 : m_conf[s] - 1;
      end
    end else if (BranchE) begin
      m_valid[s] = 1'b1;
      m_owner[s] = PCE;
      m_tgt[s]   = BrTargetE;
      m_conf[s]  = 2;
    end
  endtask

  // Drives one cycle of stimulus after the falling edge; outputs settle 1ns later.
  task automatic cyc(input logic [31:0] pcf, input bit br, input bit tk,
                     input logic [31:0] pce, input logic [31:0] tgt,
                     input bit pt, input logic [31:0] ptgt);
    @(negedge CPU_CLK);
    PCF = pcf; BrInstE = br; BranchE = tk; PCE = pce;
    BrTargetE = tgt; PredTakenE = pt; PredTargetE = ptgt;
    #1;
  endtask

  task automatic test_reset();
    CPU_RST = 1'b1;
    cyc(32'h100, 0, 0, 0, 0, 0, 0);
    model_reset();
    checks++;
    if (PredTakenF !== 1'b0) begin errors++; $display("FAIL reset_taken: got %0b want 0", PredTakenF); end
    checks++;
    if (PredTargetF !== 32'h104) begin errors++; $display("FAIL reset_target: got %h want 00000104", PredTargetF); end
    checks++;
    if (BrCount !== 32'h0 || MissCount !== 32'h0) begin
      errors++; $display("FAIL reset_counts: got br=%h miss=%h want 0/0", BrCount, MissCount);
    end
    @(negedge CPU_CLK);
    CPU_RST = 1'b0;
  endtask

  task automatic test_train_taken();
    cyc(32'h100, 1, 1, 32'h100, 32'h80, 0, 32'h104);
    checks++;
    if (MispredictE !== 1'b1 || RedirectPCE !== 32'h80) begin
      errors++; $display("FAIL train_redirect: got mp=%0b pc=%h want 1/00000080", MispredictE, RedirectPCE);
    end
    model_update();
    cyc(32'h100, 0, 0, 0, 0, 0, 0);
    checks++;
    if (PredTakenF !== 1'b1 || PredTargetF !== 32'h80) begin
      errors++; $display("FAIL train_lookup: got %0b/%h want 1/00000080", PredTakenF, PredTargetF);
    end
  endtask

  task automatic test_not_taken();
    cyc(32'h100, 1, 0, 32'h100, 32'h80, 1, 32'h80);
    checks++;
    if (MispredictE !== 1'b1 || RedirectPCE !== 32'h104) begin
      errors++; $display("FAIL nt_first: got mp=%0b pc=%h want 1/00000104", MispredictE, RedirectPCE);
    end
    model_update();
    cyc(32'h100, 1, 0, 32'h100, 32'h80, 0, 32'h104);
    checks++;
    if (MispredictE !== 1'b0) begin errors++; $display("FAIL nt_second: got mp=%0b want 0", MispredictE); end
    model_update();
    cyc(32'h100, 0, 0, 0, 0, 0, 0);
    checks++;
    if (PredTakenF !== 1'b0 || PredTargetF !== 32'h104) begin
      errors++; $display("FAIL nt_lookup: got %0b/%h want 0/00000104", PredTakenF, PredTargetF);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      cyc(32'h100, 1, 1, 32'h100, 32'h80, m_taken(32'h100), m_target(32'h100));
      model_update();
    end
    cyc(32'h100, 1, 0, 32'h100, 32'h80, 1, 32'h80);
    model_update();
    cyc(32'h100, 0, 0, 0, 0, 0, 0);
    checks++;
    if (PredTakenF !== 1'b1 || PredTargetF !== 32'h80) begin
      errors++; $display("FAIL saturate: got %0b/%h want 1/00000080", PredTakenF, PredTargetF);
    end
  endtask

  task automatic test_alias();
    cyc(32'h200, 1, 1, 32'h200, 32'h40, 0, 32'h204);
    checks++;
    if (PredTakenF !== 1'b0 || PredTargetF !== 32'h204) begin
      errors++; $display("FAIL alias_read_old: got %0b/%h want 0/00000204", PredTakenF, PredTargetF);
    end
    model_update();
    cyc(32'h100, 0, 0, 0, 0, 0, 0);
    checks++;
    if (PredTakenF !== 1'b0 || PredTargetF !== 32'h104) begin
      errors++; $display("FAIL alias_evicted: got %0b/%h want 0/00000104", PredTakenF, PredTargetF);
    end
    cyc(32'h200, 0, 0, 0, 0, 0, 0);
    checks++;
    if (PredTakenF !== 1'b1 || PredTargetF !== 32'h40) begin
      errors++; $display("FAIL alias_new: got %0b/%h want 1/00000040", PredTakenF, PredTargetF);
    end
  endtask

  task automatic test_wrap();
    cyc(32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC, 32'h10, 0, 32'h0);
    checks++;
    if (RedirectPCE !== 32'h0 || MispredictE !== 1'b0) begin
      errors++; $display("FAIL wrap_redirect: got pc=%h mp=%0b want 00000000/0", RedirectPCE, MispredictE);
    end
    checks++;
    if (PredTargetF !== m_target(32'hFFFF_FFFC)) begin
      errors++; $display("FAIL wrap_lookup: got %h want %h", PredTargetF, m_target(32'hFFFF_FFFC));
    end
    model_update();
  endtask

  task automatic test_random();
    logic [31:0] pool [8] = '{32'h100, 32'h200, 32'h300, 32'h104, 32'h1100, 32'h10, 32'hFFFF_FFFC, 32'h400};
    logic [31:0] tgts [4] = '{32'h40, 32'h80, 32'h1000, 32'hC0};
    logic [31:0] pcf, pce, tgt, ptgt;
    bit br, tk, pt;
    for (int n = 0; n < 400; n++) begin
      pcf = pool[$urandom_range(7)];
      pce = pool[$urandom_range(7)];
      tgt = tgts[$urandom_range(3)];
      br  = ($urandom_range(3) != 0);
      tk  = $urandom_range(1);
      if ($urandom_range(3) != 0) begin
        pt = m_taken(pce); ptgt = m_target(pce);
      end else begin
        pt = $urandom_range(1); ptgt = tgts[$urandom_range(3)];
      end
      cyc(pcf, br, tk, pce, tgt, pt, ptgt);
      checks++;
      if (PredTakenF !== m_taken(pcf) || PredTargetF !== m_target(pcf)) begin
        errors++; $display("FAIL rand_lookup[%0d]: pc=%h got %0b/%h want %0b/%h", n, pcf,
                           PredTakenF, PredTargetF, m_taken(pcf), m_target(pcf));
      end
      checks++;
      if (MispredictE !== (br && m_mispredict(tk, tgt, pt, ptgt))) begin
        errors++; $display("FAIL rand_mispredict[%0d]: got %0b want %0b", n, MispredictE,
                           br && m_mispredict(tk, tgt, pt, ptgt));
      end
      if (br) begin
        checks++;
        if (RedirectPCE !== (tk ? tgt : pce + 32'd4)) begin
          errors++; $display("FAIL rand_redirect[%0d]: got %h want %h", n, RedirectPCE, tk ? tgt : pce + 32'd4);
        end
      end
      model_update();
    end
    cyc(32'h100, 0, 0, 0, 0, 0, 0);
`ifdef BTB_STATS_EN
    checks++;
    if (BrCount !== exp_br || MissCount !== exp_miss) begin
      errors++; $display("FAIL rand_stats: got %h/%h want %h/%h", BrCount, MissCount, exp_br, exp_miss);
    end
`else
    checks++;
    if (BrCount !== 32'h0 || MissCount !== 32'h0) begin
      errors++; $display("FAIL stats_disabled: got %h/%h want 0/0", BrCount, MissCount);
    end
`endif
  endtask

  task automatic test_async_reset();
    cyc(32'h300, 1, 1, 32'h300, 32'h80, 0, 32'h304);
    model_update();
    cyc(32'h300, 0, 0, 0, 0, 0, 0);
    #2 CPU_RST = 1'b1;
    #1;
    model_reset();
    checks++;
    if (PredTakenF !== 1'b0 || PredTargetF !== 32'h304) begin
      errors++; $display("FAIL async_reset_lookup: got %0b/%h want 0/00000304", PredTakenF, PredTargetF);
    end
    checks++;
    if (BrCount !== 32'h0 || MissCount !== 32'h0) begin
      errors++; $display("FAIL async_reset_counts: got %h/%h want 0/0", BrCount, MissCount);
    end
    cyc(32'h400, 1, 1, 32'h400, 32'h80, 0, 32'h404);
    @(negedge CPU_CLK);
    CPU_RST = 1'b0;
    BrInstE = 1'b0;
    PCF = 32'h400;
    #1;
    checks++;
    if (PredTakenF !== 1'b0 || PredTargetF !== 32'h404) begin
      errors++; $display("FAIL reset_drops_update: got %0b/%h want 0/00000404", PredTakenF, PredTargetF);
    end
  endtask

  task automatic test_stats();
    for (int i = 0; i < 10; i++) begin
      cyc(32'h0, 1, 0, 32'h800 + 32'(i * 4), 32'h80, (i < 3), 32'h80);
      checks++;
      if (MispredictE !== (i < 3)) begin
        errors++; $display("FAIL stats_mp[%0d]: got %0b want %0b", i, MispredictE, i < 3);
      end
      model_update();
    end
    cyc(32'h0, 0, 0, 0, 0, 0, 0);
`ifdef BTB_STATS_EN
    checks++;
    if (BrCount !== 32'd10 || MissCount !== 32'd3) begin
      errors++; $display("FAIL stats_count: got %0d/%0d want 10/3", BrCount, MissCount);
    end
    force dut.br_count_q = 32'hFFFF_FFFF;
    #1 release dut.br_count_q;
    cyc(32'h0, 1, 0, 32'h900, 32'h80, 0, 32'h904);
    cyc(32'h0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (BrCount !== 32'h0) begin errors++; $display("FAIL stats_wrap: got %h want 00000000", BrCount); end
`else
    checks++;
    if (BrCount !== 32'h0 || MissCount !== 32'h0) begin
      errors++; $display("FAIL stats_tied_off: got %h/%h want 0/0", BrCount, MissCount);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_train_taken();
    test_not_taken();
    test_saturation();
    test_alias();
    test_wrap();
    test_random();
    test_async_reset();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
